// File: rtl/cmp_arbiter_pkg.sv
// rtl/cmp_arbiter_pkg.sv - shared constants and types for the comparator arbiter
package cmp_arbiter_pkg;

  localparam int DEF_WIDTH   = 14;
  localparam int FP_W        = DEF_WIDTH + 1;
  localparam int DEF_CMP_LAT = 4;

  // Two-bit exception field at the top of every operand
  typedef enum logic [1:0] {
    EXC_ZERO   = 2'b00,
    EXC_NORMAL = 2'b01,
    EXC_INF    = 2'b10,
    EXC_NAN    = 2'b11
  } exc_e;

endpackage

// File: rtl/cmp_tag_pipe.sv
// rtl/cmp_tag_pipe.sv - delay line carrying {valid, index} alongside the comparator
module cmp_tag_pipe #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_index,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_index
);

  logic [DEPTH-1:0] vld;
  logic [IDX_W-1:0] idx [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) idx[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      idx[0] <= in_index;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        idx[i] <= idx[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_index = idx[DEPTH-1];

endmodule

// File: rtl/less_than.sv
// rtl/less_than.sv - pipelined A<B comparator; operand registers load only when en is high
module less_than
  import cmp_arbiter_pkg::*;
#(
  parameter int W   = FP_W,
  parameter int LAT = DEF_CMP_LAT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         less
);

  logic [W-1:0] a_q, b_q;
  logic [LAT-2:0] pipe;
  logic lt;
  exc_e ea, eb;

  assign ea = exc_e'(a_q[W-1:W-2]);
  assign eb = exc_e'(b_q[W-1:W-2]);

  // A normal difference that is negative; magnitudes compare as unsigned {exp, frac}
  always_comb begin
    lt = 1'b0;
    if (ea == EXC_ZERO && eb == EXC_NORMAL)
      lt = ~b_q[W-3];
    else if (ea == EXC_NORMAL && eb == EXC_ZERO)
      lt = a_q[W-3];
    else if (ea == EXC_NORMAL && eb == EXC_NORMAL) begin
      if (a_q[W-3] != b_q[W-3]) lt = a_q[W-3];
      else if (a_q[W-3])        lt = a_q[W-4:0] > b_q[W-4:0];
      else                      lt = a_q[W-4:0] < b_q[W-4:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      pipe <= '0;
    end else begin
      if (en) begin
        a_q <= a;
        b_q <= b;
      end
      pipe[0] <= lt;
      for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign less = pipe[LAT-2];

endmodule

// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - round-robin sharing of one pipelined less-than comparator among NREQ requesters
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREQ    = 4,
  parameter int CMP_LAT = DEF_CMP_LAT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*(WIDTH+1)-1:0]     req_a,
  input  logic [NREQ*(WIDTH+1)-1:0]     req_b,
  output logic [NREQ-1:0]               req_ready,
  output logic [NREQ-1:0]               rsp_valid,
  output logic                          rsp_less,
  output logic [$clog2(CMP_LAT+1)-1:0]  inflight
);

  localparam int OPW   = WIDTH + 1;
  localparam int IDX_W = $clog2(NREQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
  localparam logic [IDX_W:0]   NREQ_W   = (IDX_W + 1)'(NREQ);

  logic [IDX_W-1:0] last_gnt, base, off, gnt_idx, tag_idx;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0] rot;
  logic [IDX_W:0] sum;
  logic gnt_any, tag_valid, cmp_less, cmp_rst;
  logic [OPW-1:0] a_arr [NREQ];
  logic [OPW-1:0] b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*OPW +: OPW];
    assign b_arr[i] = req_b[i*OPW +: OPW];
  end

  // Rotate so last_gnt+1 sits at bit 0, pick the lowest set bit, rotate the index back
  assign base = (last_gnt == LAST_IDX) ? '0 : last_gnt + 1'b1;
  assign dbl  = {req_valid, req_valid};

  always_comb begin
    rot     = NREQ'(dbl >> base);
    gnt_any = |rot;
    off     = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (rot[i]) off = IDX_W'(i);
    sum       = {1'b0, off} + {1'b0, base};
    gnt_idx   = (sum >= NREQ_W) ? IDX_W'(sum - NREQ_W) : sum[IDX_W-1:0];
    req_ready = (rst && gnt_any) ? (NREQ'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt <= LAST_IDX;
      inflight <= '0;
    end else begin
      if (gnt_any) last_gnt <= gnt_idx;
      if (gnt_any && !tag_valid)      inflight <= inflight + 1'b1;
      else if (!gnt_any && tag_valid) inflight <= inflight - 1'b1;
    end
  end

  assign cmp_rst = ~rst;

  less_than #(.W(OPW), .LAT(CMP_LAT)) u_cmp (
    .clk  (clk),
    .rst  (cmp_rst),
    .en   (gnt_any),
    .a    (a_arr[gnt_idx]),
    .b    (b_arr[gnt_idx]),
    .less (cmp_less)
  );

  cmp_tag_pipe #(.DEPTH(CMP_LAT), .IDX_W(IDX_W)) u_tag (
    .clk       (clk),
    .rst_n     (rst),
    .in_valid  (gnt_any),
    .in_index  (gnt_idx),
    .out_valid (tag_valid),
    .out_index (tag_idx)
  );

  assign rsp_valid = tag_valid ? (NREQ'(1) << tag_idx) : '0;
  assign rsp_less  = cmp_less & tag_valid;

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb/tb_cmp_arbiter.sv - scoreboard bench for cmp_arbiter
module tb_cmp_arbiter;

  localparam int NREQ = 4;
  localparam int CMP_LAT = 4;
  localparam int CW = $clog2(CMP_LAT + 1);

  // Operand layout: exc[14:13] sign[12] exp[11:6] (bias 31) frac[5:0]
  localparam logic [14:0] P1   = {2'b01, 1'b0, 6'd31, 6'd0};
  localparam logic [14:0] P2   = {2'b01, 1'b0, 6'd32, 6'd0};
  localparam logic [14:0] P3   = {2'b01, 1'b0, 6'd32, 6'd32};
  localparam logic [14:0] M1   = {2'b01, 1'b1, 6'd31, 6'd0};
  localparam logic [14:0] M2   = {2'b01, 1'b1, 6'd32, 6'd0};
  localparam logic [14:0] HALF = {2'b01, 1'b0, 6'd30, 6'd0};
  localparam logic [14:0] ZR   = 15'd0;
  localparam logic [14:0] MINF = {2'b10, 1'b1, 12'd0};
  localparam logic [14:0] QNAN = {2'b11, 13'd0};

  typedef struct {
    int   idx;
    logic less;
    int   due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*15-1:0] req_a, req_b;
  logic [NREQ-1:0] req_ready, rsp_valid;
  logic rsp_less;
  logic [CW-1:0] inflight;

  logic [14:0] a_op [NREQ];
  logic [14:0] b_op [NREQ];
  logic        e_less [NREQ];
  logic [14:0] pa [12];
  logic [14:0] pb [12];
  logic        pl [12];

  exp_t q[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int m_last = NREQ - 1;
  int max_inf;

  assign req_a = {a_op[3], a_op[2], a_op[1], a_op[0]};
  assign req_b = {b_op[3], b_op[2], b_op[1], b_op[0]};

  cmp_arbiter #(.WIDTH(14), .NREQ(NREQ), .CMP_LAT(CMP_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_less  (rsp_less),
    .inflight  (inflight)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model_grant(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      logic [1:0] ii;
      ii = 2'((last + k) % NREQ);
      if (v[ii]) return int'(ii);
    end
    return -1;
  endfunction

  task automatic set_op(input int r, input int k);
    a_op[r] = pa[k];
    b_op[r] = pb[k];
    e_less[r] = pl[k];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Called at posedge+1; drives one cycle of requests and records the expected response
  task automatic tick(input logic [NREQ-1:0] v);
    int g;
    logic [NREQ-1:0] exp_rdy;
    req_valid = v;
    #1;
    g = model_grant(v, m_last);
    exp_rdy = (g >= 0) ? NREQ'(1) << g : '0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (g >= 0) begin
      q.push_back('{idx: g, less: e_less[g], due: cyc + CMP_LAT - 1});
      m_last = g;
    end
    req_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    q.delete();
    m_last = NREQ - 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    check("inflight", 32'(inflight), 32'(q.size()));
    if (rsp_valid !== '0) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_rsp: rsp_valid=%b at cycle %0d, required none", rsp_valid, cyc);
      end else begin
        e = q.pop_front();
        n_chk++;
        if (rsp_valid !== (NREQ'(1) << e.idx) || rsp_less !== e.less || cyc != e.due) begin
          n_fail++;
          $display("FAIL rsp: rsp_valid=%b less=%b cycle=%0d required idx=%0d less=%b cycle=%0d",
                   rsp_valid, rsp_less, cyc, e.idx, e.less, e.due);
        end
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missing_rsp: no rsp_valid at cycle %0d, required idx=%0d at cycle %0d",
               cyc, e.idx, e.due);
    end
  end

  initial begin
    pa[0] = P1;   pb[0] = P2;   pl[0] = 1'b1;
    pa[1] = P2;   pb[1] = P1;   pl[1] = 1'b0;
    pa[2] = P3;   pb[2] = P3;   pl[2] = 1'b0;
    pa[3] = M2;   pb[3] = M1;   pl[3] = 1'b1;
    pa[4] = M1;   pb[4] = M2;   pl[4] = 1'b0;
    pa[5] = ZR;   pb[5] = P1;   pl[5] = 1'b1;
    pa[6] = P1;   pb[6] = ZR;   pl[6] = 1'b0;
    pa[7] = M1;   pb[7] = ZR;   pl[7] = 1'b1;
    pa[8] = MINF; pb[8] = P1;   pl[8] = 1'b0;
    pa[9] = QNAN; pb[9] = P1;   pl[9] = 1'b0;
    pa[10] = M1;  pb[10] = HALF; pl[10] = 1'b1;
    pa[11] = HALF; pb[11] = P3;  pl[11] = 1'b1;
    for (int r = 0; r < NREQ; r++) set_op(r, 0);

    // Reset state with every requester asking
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 32'(req_ready), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_less", 32'(rsp_less), 32'h0);
    check("reset_inflight", 32'(inflight), 32'h0);
    req_valid = '0;
    rst = 1'b1;

    // Single request 1.0 < 2.0
    set_op(0, 0);
    tick(4'b0001);
    repeat (CMP_LAT + 2) tick(4'b0000);

    // All four valid after reset: grants 0,1,2,3,0,1,2,3
    do_reset();
    set_op(0, 0); set_op(1, 1); set_op(2, 3); set_op(3, 8);
    repeat (8) tick(4'b1111);
    repeat (CMP_LAT + 2) tick(4'b0000);

    // Edge operands on requester 0
    set_op(0, 2); tick(4'b0001);
    set_op(0, 8); tick(4'b0001);
    set_op(0, 3); tick(4'b0001);
    set_op(0, 9); tick(4'b0001);
    set_op(0, 7); tick(4'b0001);
    repeat (CMP_LAT + 2) tick(4'b0000);

    // Requester 2 streams back-to-back
    max_inf = 0;
    for (int k = 0; k < 10; k++) begin
      set_op(2, k);
      tick(4'b0100);
      if (int'(inflight) > max_inf) max_inf = int'(inflight);
    end
    check("inflight_sat", 32'(max_inf), 32'(CMP_LAT));
    repeat (CMP_LAT + 2) tick(4'b0000);

    // Reset with three requests in flight
    set_op(1, 5);
    repeat (3) tick(4'b0010);
    req_valid = 4'b1010;
    rst = 1'b0;
    q.delete();
    m_last = NREQ - 1;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midrst_inflight", 32'(inflight), 32'h0);
    check("midrst_ready", 32'(req_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = '0;
    set_op(3, 11);
    tick(4'b1010);
    repeat (CMP_LAT + 2) tick(4'b0000);

    // Requesters 1 and 3 toggle randomly
    for (int k = 0; k < 1000; k++) begin
      logic [NREQ-1:0] v;
      v = {1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0};
      set_op(1, int'($urandom_range(0, 11)));
      set_op(3, int'($urandom_range(0, 11)));
      tick(v);
    end
    repeat (CMP_LAT + 4) tick(4'b0000);
    check("queue_drained", 32'(q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
